// File: rtl/spram_banked_mem.sv
`default_nettype none
// ============================================================================
// Module   : spram_banked_mem_sp256 / spram_banked_mem
// Brief    : 32-bit main memory built from NUM_BANKS pairs of 16K x 16
//            single-port RAMs, with cs/ready handshake and a scrub engine
//            that zeroises the whole array after reset and on request.
// Revision : 1.0 - initial release
// ============================================================================

// 16K x 16 single-port RAM carrying the SB_SPRAM256KA port set: registered
// read output, one MASKWREN bit per 4-bit nibble, POWEROFF active low.
module spram_banked_mem_sp256 (
    input  logic        CLOCK,
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);
    logic [15:0] mem_q [0:16383];
    logic [15:0] dataout_q;
    logic [15:0] word_d;
    logic        active;

    assign active  = CHIPSELECT && POWEROFF && !SLEEP && !STANDBY;
    assign DATAOUT = dataout_q;

    // Merge the incoming nibbles selected by MASKWREN into the stored word
    always_comb begin
        word_d = mem_q[ADDRESS];
        for (int i = 0; i < 4; i++) begin
            if (MASKWREN[i]) begin
                word_d[4*i +: 4] = DATAIN[4*i +: 4];
            end
        end
    end

    // Array write or registered read; the output holds during writes
    always_ff @(posedge CLOCK) begin
        if (active) begin
            if (WREN) begin
                mem_q[ADDRESS] <= word_d;
            end else begin
                dataout_q <= mem_q[ADDRESS];
            end
        end
    end
endmodule

// Banked memory controller: request handshake, bank steering and scrubbing.
module spram_banked_mem #(
    parameter  int NUM_BANKS      = 2,
    parameter  bit CLEAR_ON_RESET = 1'b1,
    localparam int ADDR_WIDTH     = 14 + ((NUM_BANKS == 2) ? 1 : 0)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    input  logic                  clear,
    output logic                  busy
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SCRUB = 1'b1
    } state_t;

    localparam state_t      RESET_STATE = CLEAR_ON_RESET ? ST_SCRUB : ST_IDLE;
    localparam logic        RESET_BUSY  = CLEAR_ON_RESET;
    localparam logic [13:0] SCRUB_LAST  = 14'h3FFF;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        bank_q, bank_d;
    logic [13:0] cnt_q, cnt_d;

    logic                        bank_sel;
    logic                        accept;
    logic                        scrubbing;
    logic [13:0]                 sp_addr;
    logic [31:0]                 sp_din;
    logic [3:0]                  sp_mask_lo;
    logic [3:0]                  sp_mask_hi;
    logic                        sp_wren;
    logic [NUM_BANKS-1:0]        bank_cs;
    logic [NUM_BANKS-1:0][31:0]  bank_dout;
    logic [31:0]                 sel_dout;

    // Bank select bit exists only in the two-bank build
    generate
        if (NUM_BANKS == 2) begin : g_sel_two
            assign bank_sel = address[14];
            assign sel_dout = bank_q ? bank_dout[1] : bank_dout[0];
        end else begin : g_sel_one
            logic unused_bank;
            assign bank_sel    = 1'b0;
            assign unused_bank = bank_q;
            assign sel_dout    = bank_dout[0];
        end
    endgenerate

    // A request is taken only when idle, not mid-completion and no clear pending
    assign scrubbing = (state_q == ST_SCRUB);
    assign accept    = (state_q == ST_IDLE) && cs && !ready_q && !busy_q && !clear;

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign read_data = ready_q ? sel_dout : 32'h0000_0000;

    // Next-state logic for the IDLE/SCRUB controller
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        ready_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_SCRUB;
                    busy_d  = 1'b1;
                    cnt_d   = 14'd0;
                end else if (accept) begin
                    ready_d = 1'b1;
                    bank_d  = bank_sel;
                end
            end
            ST_SCRUB: begin
                cnt_d = cnt_q + 14'd1;
                if (cnt_q == SCRUB_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = RESET_STATE;
                busy_d  = RESET_BUSY;
            end
        endcase
    end

    // Controller registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            busy_q  <= RESET_BUSY;
            ready_q <= 1'b0;
            bank_q  <= 1'b0;
            cnt_q   <= 14'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shared RAM controls: scrub writes zero everywhere, else pass the request
    always_comb begin
        if (scrubbing) begin
            sp_addr    = cnt_q;
            sp_din     = 32'h0000_0000;
            sp_wren    = 1'b1;
            sp_mask_lo = 4'hF;
            sp_mask_hi = 4'hF;
        end else begin
            sp_addr    = address[13:0];
            sp_din     = write_data;
            sp_wren    = |we;
            sp_mask_lo = {we[1], we[1], we[0], we[0]};
            sp_mask_hi = {we[3], we[3], we[2], we[2]};
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign bank_cs[b] = scrubbing || (accept && (bank_sel == 1'(b)));

            spram_banked_mem_sp256 u_lo (
                .CLOCK      (clk),
                .ADDRESS    (sp_addr),
                .DATAIN     (sp_din[15:0]),
                .MASKWREN   (sp_mask_lo),
                .WREN       (sp_wren),
                .CHIPSELECT (bank_cs[b]),
                .STANDBY    (1'b0),
                .SLEEP      (1'b0),
                .POWEROFF   (1'b1),
                .DATAOUT    (bank_dout[b][15:0])
            );

            spram_banked_mem_sp256 u_hi (
                .CLOCK      (clk),
                .ADDRESS    (sp_addr),
                .DATAIN     (sp_din[31:16]),
                .MASKWREN   (sp_mask_hi),
                .WREN       (sp_wren),
                .CHIPSELECT (bank_cs[b]),
                .STANDBY    (1'b0),
                .SLEEP      (1'b0),
                .POWEROFF   (1'b1),
                .DATAOUT    (bank_dout[b][31:16])
            );
        end
    endgenerate
endmodule
`default_nettype wire

// File: doc/spram_banked_mem.md
Name: spram_banked_mem

Overview:
- Parametrised successor to the fixed 128 KiB SPRAM wrapper: a 32-bit wide main memory built from NUM_BANKS pairs of SB_SPRAM256KA blocks.
- Each pair provides 16K x 32 bit (64 KiB).
- Adds a cs/ready request handshake with one-access-per-request semantics.
- Adds a hardware scrub engine that zeroises the whole memory after reset (optional) and on request.
- Read data is muxed from the bank latched at request acceptance.
- Sits between the CPU bus decoder and the SPRAM primitives.

Parameters:
NUM_BANKS, 2, number of 64 KiB SPRAM pairs; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = start a full scrub automatically when reset is released.
ADDR_WIDTH, derived, 14 + (NUM_BANKS == 2 ? 1 : 0); not user-overridable.

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active low
cs  input  1  access request, held with address/we/write_data until ready
we  input  4  byte write enables; 0000 = read
address  input  ADDR_WIDTH  32-bit word address; bit 14 selects the bank when NUM_BANKS = 2
write_data  input  32  write data
read_data  output  32  read data, valid while ready = 1 for a read
ready  output  1  one-cycle completion pulse
clear  input  1  single-cycle scrub request
busy  output  1  high while a scrub is in progress

Behaviour:
- Reset values: ready = 0; read_data = 0; bank index register = 0; scrub counter = 0.
- Reset value of busy: 1 when CLEAR_ON_RESET = 1, else 0.
- Reset state: SCRUB when CLEAR_ON_RESET = 1, else IDLE.
- States:
  - IDLE: memory is accepting requests.
  - SCRUB: memory is being zeroised.
- IDLE, acceptance rule:
  - A request is accepted in a cycle where cs = 1, ready = 0, busy = 0 and clear = 0.
  - The selected bank pair is chip-selected in that cycle.
  - WREN = |we for the pair; MASKWREN follows the per-byte enables as in the 16-bit halves.
  - The bank index is registered on acceptance.
- Latency: ready = 1 exactly one cycle after acceptance, for exactly one cycle.
  - read_data = DATAOUT of the registered bank while ready = 1.
  - read_data = 0 otherwise.
- Back-to-back requests:
  - No request is accepted in a cycle where ready = 1, so a cs held through the ready cycle is never double-issued.
  - Maximum throughput is one access per 2 cycles.
- No chip select to any SPRAM when no request is accepted.
- clear = 1 in IDLE: enter SCRUB next cycle, with busy = 1 next cycle. This has priority over a simultaneous cs, which is not accepted and stays pending.
- If a request was accepted in the previous cycle, its ready pulse still completes normally in the cycle SCRUB is entered.
- SCRUB:
  - Every cycle, all banks are chip-selected together.
  - Writes use address = scrub counter, data = 0, MASKWREN = 1111.
  - The 14-bit counter increments by 1 per cycle.
  - Duration: 16384 cycles regardless of NUM_BANKS.
  - After the write at counter = 16383: counter wraps to 0, busy drops to 0 the next cycle, state returns to IDLE.
- During SCRUB:
  - cs is ignored and held requests stay pending.
  - ready = 0.
  - clear is ignored; it neither restarts nor extends the scrub.
- Reset asserted mid-scrub or mid-access:
  - All registers return to reset values immediately.
  - An in-flight ready is lost.
  - A partial scrub restarts from 0 when CLEAR_ON_RESET = 1; otherwise memory is left partially cleared.
- Unused SPRAM controls: STANDBY = 0, SLEEP = 0, POWEROFF = 1.
- With NUM_BANKS = 1, address bit 14 does not exist and only one pair is instantiated.

Test Plan:
1. CLEAR_ON_RESET = 1, release reset → busy = 1 for exactly 16384 cycles, then 0; reads of 0x0000, 0x3FFF and 0x7FFF return 0x00000000.
2. Write 0xDEADBEEF to address 0x4001 with we = 1111, then read 0x4001 and 0x0001 → 0xDEADBEEF and 0x00000000; ready exactly 1 cycle after each acceptance.
3. Write 0xAABBCCDD, then write 0x11223344 with we = 0101 to the same address → read returns 0xAA22CC44.
4. Hold cs high through two full transactions → exactly two ready pulses, spaced 2 cycles apart; no extra SPRAM write observed.
5. Pulse clear in the same cycle as cs → access not accepted; busy = 1 next cycle; after the scrub the held access completes, and a read returns 0.
6. Assert reset_n low at scrub counter = 100 → busy resets; on release, the scrub restarts at address 0 and again lasts 16384 cycles.
